exe_stage: RTL and testbench

EXE_STAGE -- requirements
Module: exe_stage

---
 rtl/exe_stage_pkg.sv | 58 +++++
 rtl/mul_iter.sv | 67 ++++++
 rtl/exe_stage.sv | 132 +++++++++++++
 tb/tb_exe_stage.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/exe_stage_pkg.sv
// Shared encodings for the execute stage: ALU operation codes, instruction
// types, multiplier FSM states and the operand-forwarding helper.
package exe_stage_pkg;

  typedef enum logic [3:0] {
    AluAdd = 4'd0,
    AluSub = 4'd1,
    AluAnd = 4'd2,
    AluOr  = 4'd3,
    AluXor = 4'd4,
    AluNor = 4'd5,
    AluSlt = 4'd6,
    AluSll = 4'd7,
    AluSrl = 4'd8,
    AluSra = 4'd9,
    AluLui = 4'd10,
    AluMul = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    InstAlu = 2'b00,
    InstMem = 2'b01,
    InstBeq = 2'b10,
    InstJ   = 2'b11
  } inst_type_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } mul_state_e;

  localparam int unsigned MulSteps = 32;

  // MEM result wins over WB result; register 0 is hard-wired and never forwarded.
  function automatic logic [31:0] fwd_select(
    input logic [4:0]  num,
    input logic [31:0] gpr,
    input logic        mem_en,
    input logic [4:0]  mem_num,
    input logic [31:0] mem_data,
    input logic        wb_en,
    input logic [4:0]  wb_num,
    input logic [31:0] wb_data
  );
    logic [31:0] val;
    val = gpr;
    if (num != 5'd0) begin
      if (mem_en && (mem_num == num)) begin
        val = mem_data;
      end else if (wb_en && (wb_num == num)) begin
        val = wb_data;
      end
    end
    return val;
  endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative 32x32 shift-add multiplier (low 32 bits of the unsigned product).
// Ports: clock, reset (sync, active-low), start (accepted in idle), a/b operands,
// busy (iterating), done (product valid this cycle), product.
module mul_iter
  import exe_stage_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  mul_state_e  state_q;
  logic [4:0]  count_q;
  logic [31:0] acc_q;
  logic [31:0] mcand_q;
  logic [31:0] mplier_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= StIdle;
      count_q  <= 5'd0;
      acc_q    <= 32'd0;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            acc_q    <= 32'd0;
            mcand_q  <= a;
            mplier_q <= b;
            count_q  <= 5'd0;
            state_q  <= StBusy;
          end
        end
        StBusy: begin
          if (mplier_q[0]) begin
            acc_q <= acc_q + mcand_q;
          end
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          if (count_q == 5'(MulSteps - 1)) begin
            state_q <= StDone;
          end else begin
            count_q <= count_q + 5'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy    = (state_q == StBusy);
  assign done    = (state_q == StDone);
  assign product = acc_q;

endmodule

// File: rtl/exe_stage.sv
// Pipeline execute stage: operand forwarding, ALU, branch resolution and the
// EXE/MEM register. MUL runs on the iterative multiplier and stalls the pipe.
// Inputs: ID/EXE fields (*_in), MEM/WB forwarding buses. Outputs: registered
// EXE/MEM fields (*_out), combinational branch_taken/branch_target/stall.
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        s_b_in,
  input  logic        mem_write_in,
  input  logic        reg_write_in,
  input  logic [1:0]  s_data_write_in,
  input  logic [1:0]  inst_type_in,
  input  logic [4:0]  rs_in,
  input  logic [4:0]  rt_in,
  input  logic [4:0]  shamt_in,
  input  logic [4:0]  num_write_in,
  input  logic [3:0]  alu_op_in,
  input  logic [31:0] npc_in,
  input  logic [31:0] ext_imm_in,
  input  logic [31:0] gpr_a_in,
  input  logic [31:0] gpr_b_in,
  input  logic        mem_fwd_en,
  input  logic [4:0]  mem_fwd_num,
  input  logic [31:0] mem_fwd_data,
  input  logic        wb_fwd_en,
  input  logic [4:0]  wb_fwd_num,
  input  logic [31:0] wb_fwd_data,
  output logic [31:0] alu_result_out,
  output logic [31:0] store_data_out,
  output logic [31:0] npc_out,
  output logic        mem_write_out,
  output logic        reg_write_out,
  output logic [1:0]  s_data_write_out,
  output logic [4:0]  num_write_out,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic        stall
);

  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic [31:0] op_b;
  logic [31:0] alu_result;
  logic        mul_start;
  logic        mul_busy;
  logic        mul_done;
  logic [31:0] mul_product;

  assign fwd_a = fwd_select(rs_in, gpr_a_in, mem_fwd_en, mem_fwd_num, mem_fwd_data,
                            wb_fwd_en, wb_fwd_num, wb_fwd_data);
  assign fwd_b = fwd_select(rt_in, gpr_b_in, mem_fwd_en, mem_fwd_num, mem_fwd_data,
                            wb_fwd_en, wb_fwd_num, wb_fwd_data);
  assign op_b  = s_b_in ? ext_imm_in : fwd_b;

  // A MUL is accepted only from idle; in the done cycle the same held MUL
  // retires instead of restarting.
  assign mul_start = (alu_op_in == AluMul) && !mul_busy && !mul_done;
  assign stall     = reset && (mul_start || mul_busy);

  mul_iter u_mul_iter (
    .clock   (clock),
    .reset   (reset),
    .start   (mul_start),
    .a       (fwd_a),
    .b       (fwd_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    alu_result = 32'd0;
    case (alu_op_in)
      AluAdd:  alu_result = fwd_a + op_b;
      AluSub:  alu_result = fwd_a - op_b;
      AluAnd:  alu_result = fwd_a & op_b;
      AluOr:   alu_result = fwd_a | op_b;
      AluXor:  alu_result = fwd_a ^ op_b;
      AluNor:  alu_result = ~(fwd_a | op_b);
      AluSlt:  alu_result = {31'd0, ($signed(fwd_a) < $signed(op_b))};
      AluSll:  alu_result = op_b << shamt_in;
      AluSrl:  alu_result = op_b >> shamt_in;
      AluSra:  alu_result = 32'($signed(op_b) >>> shamt_in);
      AluLui:  alu_result = {op_b[15:0], 16'h0000};
      AluMul:  alu_result = mul_product;
      default: alu_result = 32'd0;
    endcase
  end

  always_comb begin
    branch_taken  = 1'b0;
    branch_target = 32'd0;
    case (inst_type_in)
      InstBeq: begin
        branch_taken  = (fwd_a == fwd_b);
        branch_target = npc_in + (ext_imm_in << 2);
      end
      InstJ: begin
        branch_taken  = 1'b1;
        branch_target = {npc_in[31:28], ext_imm_in[25:0], 2'b00};
      end
      default: ;
    endcase
    if (stall || !reset) begin
      branch_taken = 1'b0;
    end
  end

  // Reset and stall both load a bubble into EXE/MEM.
  always_ff @(posedge clock) begin
    if (!reset || stall) begin
      alu_result_out   <= 32'd0;
      store_data_out   <= 32'd0;
      npc_out          <= 32'd0;
      mem_write_out    <= 1'b0;
      reg_write_out    <= 1'b0;
      s_data_write_out <= 2'd0;
      num_write_out    <= 5'd0;
    end else begin
      alu_result_out   <= alu_result;
      store_data_out   <= fwd_b;
      npc_out          <= npc_in;
      mem_write_out    <= mem_write_in;
      reg_write_out    <= reg_write_in;
      s_data_write_out <= s_data_write_in;
      num_write_out    <= num_write_in;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;

  logic        clock;
  logic        reset;
  logic        s_b_in, mem_write_in, reg_write_in;
  logic [1:0]  s_data_write_in, inst_type_in;
  logic [4:0]  rs_in, rt_in, shamt_in, num_write_in;
  logic [3:0]  alu_op_in;
  logic [31:0] npc_in, ext_imm_in, gpr_a_in, gpr_b_in;
  logic        mem_fwd_en, wb_fwd_en;
  logic [4:0]  mem_fwd_num, wb_fwd_num;
  logic [31:0] mem_fwd_data, wb_fwd_data;
  logic [31:0] alu_result_out, store_data_out, npc_out;
  logic        mem_write_out, reg_write_out;
  logic [1:0]  s_data_write_out;
  logic [4:0]  num_write_out;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        stall;

  int errors = 0;
  int checks = 0;
  int n;

  exe_stage dut (
    .clock            (clock),
    .reset            (reset),
    .s_b_in           (s_b_in),
    .mem_write_in     (mem_write_in),
    .reg_write_in     (reg_write_in),
    .s_data_write_in  (s_data_write_in),
    .inst_type_in     (inst_type_in),
    .rs_in            (rs_in),
    .rt_in            (rt_in),
    .shamt_in         (shamt_in),
    .num_write_in     (num_write_in),
    .alu_op_in        (alu_op_in),
    .npc_in           (npc_in),
    .ext_imm_in       (ext_imm_in),
    .gpr_a_in         (gpr_a_in),
    .gpr_b_in         (gpr_b_in),
    .mem_fwd_en       (mem_fwd_en),
    .mem_fwd_num      (mem_fwd_num),
    .mem_fwd_data     (mem_fwd_data),
    .wb_fwd_en        (wb_fwd_en),
    .wb_fwd_num       (wb_fwd_num),
    .wb_fwd_data      (wb_fwd_data),
    .alu_result_out   (alu_result_out),
    .store_data_out   (store_data_out),
    .npc_out          (npc_out),
    .mem_write_out    (mem_write_out),
    .reg_write_out    (reg_write_out),
    .s_data_write_out (s_data_write_out),
    .num_write_out    (num_write_out),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .stall            (stall)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic bubble();
    s_b_in = 0; mem_write_in = 0; reg_write_in = 0; s_data_write_in = 0;
    inst_type_in = 0; rs_in = 0; rt_in = 0; shamt_in = 0; num_write_in = 0;
    alu_op_in = 0; npc_in = 0; ext_imm_in = 0; gpr_a_in = 0; gpr_b_in = 0;
    mem_fwd_en = 0; mem_fwd_num = 0; mem_fwd_data = 0;
    wb_fwd_en = 0; wb_fwd_num = 0; wb_fwd_data = 0;
  endtask

  task automatic run_alu(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic sb, input logic [31:0] imm,
                         input logic [4:0] sh, input logic [31:0] exp);
    bubble();
    alu_op_in = op; gpr_a_in = a; gpr_b_in = b; s_b_in = sb; ext_imm_in = imm;
    shamt_in = sh;
    step();
    check(tag, alu_result_out, exp);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_alu"}, alu_result_out, 32'd0);
    check({tag, "_store"}, store_data_out, 32'd0);
    check({tag, "_npc"}, npc_out, 32'd0);
    check({tag, "_ctl"}, {27'd0, mem_write_out, reg_write_out, s_data_write_out,
                          1'b0}, 32'd0);
    check({tag, "_num"}, {27'd0, num_write_out}, 32'd0);
  endtask

  initial begin
    bubble();
    reset = 0;
    // Non-bubble inputs during reset must not reach the outputs.
    alu_op_in = 4'd0; gpr_a_in = 5; gpr_b_in = 7; reg_write_in = 1; num_write_in = 9;
    npc_in = 32'h44; mem_write_in = 1;
    step();
    step();
    check_zero_outputs("reset");
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_branch", {31'd0, branch_taken}, 32'd0);

    reset = 1;
    bubble();
    alu_op_in = 4'd0; gpr_a_in = 5; gpr_b_in = 7; reg_write_in = 1; num_write_in = 9;
    npc_in = 32'h44; mem_write_in = 1; s_data_write_in = 2'd2;
    step();
    check("add_result", alu_result_out, 32'd12);
    check("add_store", store_data_out, 32'd7);
    check("add_npc", npc_out, 32'h44);
    check("add_regw", {31'd0, reg_write_out}, 32'd1);
    check("add_memw", {31'd0, mem_write_out}, 32'd1);
    check("add_sdw", {30'd0, s_data_write_out}, 32'd2);
    check("add_num", {27'd0, num_write_out}, 32'd9);

    run_alu("sub_wrap", 4'd1, 32'd3, 32'd5, 0, 0, 0, 32'hFFFFFFFE);
    run_alu("and", 4'd2, 32'hF0F0, 32'hFF00, 0, 0, 0, 32'hF000);
    run_alu("or", 4'd3, 32'hF0F0, 32'h0F0F, 0, 0, 0, 32'hFFFF);
    run_alu("xor", 4'd4, 32'hFF, 32'h0F, 0, 0, 0, 32'hF0);
    run_alu("nor", 4'd5, 32'd0, 32'd0, 0, 0, 0, 32'hFFFFFFFF);
    run_alu("slt_neg", 4'd6, 32'hFFFFFFFF, 32'd1, 0, 0, 0, 32'd1);
    run_alu("slt_pos", 4'd6, 32'd1, 32'hFFFFFFFF, 0, 0, 0, 32'd0);
    run_alu("sll", 4'd7, 32'd0, 32'd1, 0, 0, 5'd31, 32'h80000000);
    run_alu("srl", 4'd8, 32'd0, 32'h80000000, 0, 0, 5'd4, 32'h08000000);
    run_alu("sra", 4'd9, 32'd0, 32'h80000000, 0, 0, 5'd4, 32'hF8000000);
    run_alu("lui", 4'd10, 32'd0, 32'd0, 1, 32'h1234, 0, 32'h12340000);
    run_alu("add_imm_wrap", 4'd0, 32'hFFFFFFFF, 32'd0, 1, 32'd1, 0, 32'd0);
    run_alu("op12", 4'd12, 32'd5, 32'd7, 0, 0, 0, 32'd0);
    run_alu("op15", 4'd15, 32'd5, 32'd7, 0, 0, 0, 32'd0);

    // Forwarding priority.
    bubble();
    gpr_a_in = 32'h11; gpr_b_in = 32'h22; s_b_in = 1; rs_in = 3; rt_in = 3;
    mem_fwd_en = 1; mem_fwd_num = 3; mem_fwd_data = 32'hAA;
    wb_fwd_en = 1; wb_fwd_num = 3; wb_fwd_data = 32'hBB;
    step();
    check("fwd_mem_a", alu_result_out, 32'hAA);
    check("fwd_mem_b", store_data_out, 32'hAA);
    mem_fwd_en = 0;
    step();
    check("fwd_wb_a", alu_result_out, 32'hBB);
    check("fwd_wb_b", store_data_out, 32'hBB);
    mem_fwd_en = 1; rs_in = 0; rt_in = 0;
    step();
    check("fwd_r0_a", alu_result_out, 32'h11);
    check("fwd_r0_b", store_data_out, 32'h22);

    // Branches.
    bubble();
    inst_type_in = 2'b10; npc_in = 32'h100; ext_imm_in = 32'hFFFFFFFF;
    rs_in = 1; rt_in = 2; gpr_a_in = 7; gpr_b_in = 7;
    #1;
    check("beq_taken", {31'd0, branch_taken}, 32'd1);
    check("beq_target", branch_target, 32'hFC);
    gpr_b_in = 8;
    #1;
    check("beq_not_taken", {31'd0, branch_taken}, 32'd0);
    wb_fwd_en = 1; wb_fwd_num = 2; wb_fwd_data = 7;
    #1;
    check("beq_fwd_taken", {31'd0, branch_taken}, 32'd1);
    bubble();
    inst_type_in = 2'b11; npc_in = 32'h40000004; ext_imm_in = 32'h10;
    #1;
    check("j_taken", {31'd0, branch_taken}, 32'd1);
    check("j_target", branch_target, 32'h40000040);
    inst_type_in = 2'b00;
    #1;
    check("alu_no_branch", {31'd0, branch_taken}, 32'd0);
    step();

    // MUL: 0xFFFF * 0x10001 = 0xFFFFFFFF after a 33-cycle stall.
    bubble();
    alu_op_in = 4'd11; gpr_a_in = 32'hFFFF; gpr_b_in = 32'h10001; rs_in = 1; rt_in = 2;
    reg_write_in = 1; num_write_in = 5; npc_in = 32'h200; inst_type_in = 2'b11;
    #1;
    check("mul_branch_masked", {31'd0, branch_taken}, 32'd0);
    n = 0;
    while (stall && n < 40) begin
      n++;
      step();
      check("mul_bubble_alu", alu_result_out, 32'd0);
      check("mul_bubble_regw", {31'd0, reg_write_out}, 32'd0);
    end
    check("mul_stall_cycles", n, 32'd33);
    step();
    check("mul_product", alu_result_out, 32'hFFFFFFFF);
    check("mul_regw", {31'd0, reg_write_out}, 32'd1);
    check("mul_num", {27'd0, num_write_out}, 32'd5);
    check("mul_npc", npc_out, 32'h200);
    // Held MUL starts again from idle.
    check("mul_restart_stall", {31'd0, stall}, 32'd1);
    step();
    repeat (10) step();
    check("mul_busy10_stall", {31'd0, stall}, 32'd1);

    // Reset during BUSY, with a live ADD presented.
    reset = 0;
    bubble();
    gpr_a_in = 5; gpr_b_in = 7; reg_write_in = 1; num_write_in = 9; npc_in = 32'h44;
    step();
    check_zero_outputs("midmul_reset");
    reset = 1;
    #1;
    check("post_reset_stall", {31'd0, stall}, 32'd0);
    step();
    check("post_reset_add", alu_result_out, 32'd12);
    check("post_reset_regw", {31'd0, reg_write_out}, 32'd1);

    // Flushed bubble, with forwarding buses still active.
    bubble();
    mem_fwd_en = 1; mem_fwd_num = 0; mem_fwd_data = 32'hDEAD;
    step();
    check_zero_outputs("bubble");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
